mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
//  MEM stage plus MEM/WB pipeline register, directly downstream of the EX/MEM register.
//  Resolves beq/bne from Branch/Bne/Zero and runs a req/ack handshake to a multicycle data memory.
//  Stalls upstream while an access is outstanding, then hands a registered result to write-back.
// PARAMETERS
//  DATA_W      32  datapath / memory word width
//  REG_ADDR_W  5   register-file address width
//  MEM_TIMEOUT 15  max cycles in ACCESS before abandoning the access
// PORTS
//  Clk             in   1           clock; all state on posedge
//  Reset_n         in   1           asynchronous, active-low reset
//  BranchTarget_in in   DATA_W      branch target from EX/MEM
//  Zero_in         in   1           ALU zero flag from EX/MEM
//  ALU_Result_in   in   DATA_W      ALU result / memory address
//  ReadData2_in    in   DATA_W      store data
//  WriteReg_in     in   REG_ADDR_W  destination register (RegDst mux result)
//  RegWrite_in     in   1           control from EX/MEM
//  WriteRemainder_in in 1           control from EX/MEM (div)
//  Branch_in       in   1           control from EX/MEM
//  Bne_in          in   1           control from EX/MEM (1=bne, 0=beq)
//  MemRead_in      in   1           load
//  MemWrite_in     in   1           store
//  Mem_Req         out  1           memory request, level, held until ack
//  Mem_We          out  1           1=write
//  Mem_Addr        out  DATA_W      held stable while Mem_Req
//  Mem_WData       out  DATA_W      held stable while Mem_Req
//  Mem_Ack         in   1           one-cycle completion strobe
//  Mem_RData       in   DATA_W      valid when Mem_Ack & ~Mem_We
//  Stall           out  1           upstream must hold EX/MEM contents
//  PCSrc           out  1           registered taken-branch pulse; also flush IF/ID, ID/EX
//  BranchPC        out  DATA_W      registered target, valid with PCSrc
//  ALU_Result_out  out  DATA_W      MEM/WB copy of ALU_Result_in
//  MemData_out     out  DATA_W      MEM/WB load data
//  WriteReg_out    out  REG_ADDR_W  MEM/WB destination register
//  RegWrite_out    out  1           MEM/WB control
//  MemToReg_out    out  1           MEM/WB control
//  WriteRemainder_out out 1         MEM/WB control
//  Mem_Err         out  1           sticky timeout flag
// BEHAVIOUR
//  - Reset (async, Reset_n=0): every output and register 0, FSM=IDLE, timeout counter=0; Mem_Req drops immediately, including mid-access. A pending access is lost.
//  - FSM IDLE/ACCESS.
//    - IDLE: MemRead_in|MemWrite_in and no branch -> ACCESS next cycle; Mem_Addr/WData/We latched at that edge.
//    - ACCESS: Mem_Req=1; Mem_Ack -> IDLE.
//  - Stall = (state==ACCESS & ~Mem_Ack) | (state==IDLE & mem op pending). Combinational.
//  - Non-memory op: 1-cycle latency; inputs registered into MEM/WB at next posedge, MemToReg_out=0.
//  - While Stall=1, MEM/WB receives a bubble (RegWrite_out=WriteRemainder_out=MemToReg_out=0).
//  - Ack edge completes the op into MEM/WB.
//    - Load: MemData_out<=Mem_RData, MemToReg_out=1.
//    - Store: RegWrite_out=0.
//  - MemRead & MemWrite together: store wins, treated as store.
//  - Branch: taken = Branch_in & (Zero_in ^ Bne_in). Registered; PCSrc high exactly 1 cycle, BranchPC=BranchTarget_in.
//  - A branch carries no register write. Branch with MemRead/MemWrite: branch wins, memory op suppressed.
//  - Timeout: counter increments each ACCESS cycle without ack, clears on entering ACCESS.
//    - Reaching MEM_TIMEOUT: Mem_Req drops, bubble issued, ->IDLE, Mem_Err=1.
//    - Mem_Err cleared only by reset. Ack arriving in the same cycle as the limit wins (no error).
//  - Mem_Ack outside ACCESS is ignored.
// STRUCTURE
//  - Shared package: opcode constants (ADDI 6'b001000, BEQ 6'b000100, BNE 6'b000101, RTYPE 6'b000000), FSM state encoding, DATA_W/REG_ADDR_W defaults.
//  - One sub-module: mem_handshake_fsm (state, timeout counter, Mem_Req/We/Addr/WData, Stall, Mem_Err).
//  - MEM/WB register and branch logic live in the top level.
// TESTING
//  1. addi, ALU_Result_in=0x0000_0007, WriteReg_in=5, RegWrite_in=1 -> next cycle RegWrite_out=1, WriteReg_out=5, ALU_Result_out=7, Stall never 1.
//  2. load addr 0x40, Mem_Ack after 3 cycles with RData 0xDEAD_BEEF -> Stall=1 for 4 cycles, Mem_Addr=0x40 stable; then MemData_out=0xDEADBEEF, MemToReg_out=1.
//  3. beq Zero_in=1 -> PCSrc=1 one cycle, BranchPC=target; bne Zero_in=1 -> PCSrc stays 0; bne Zero_in=0 -> PCSrc=1.
//  4. store, no ack -> Mem_Req high 15 cycles then 0, Mem_Err=1 sticky, RegWrite_out=0; ack on cycle 15 -> Mem_Err stays 0.
//  5. Reset_n=0 mid-ACCESS between clock edges -> Mem_Req, Stall, all outputs 0 immediately; after release a late Mem_Ack is ignored.

Source files
------------

// File: rtl/mem_wb_stage_pkg.sv
// rtl/mem_wb_stage_pkg.sv - shared constants and helpers for the MEM stage and MEM/WB register
package mem_wb_stage_pkg;

  localparam int DATA_W_DEF      = 32;
  localparam int REG_ADDR_W_DEF  = 5;
  localparam int MEM_TIMEOUT_DEF = 15;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  // beq takes on zero, bne takes on non-zero
  function automatic logic branch_taken(input logic branch, input logic zero, input logic bne);
    return branch & (zero ^ bne);
  endfunction

endpackage

// File: rtl/mem_wb_stage_mem_handshake_fsm.sv
// rtl/mem_wb_stage_mem_handshake_fsm.sv - req/ack handshake to the multicycle data memory
// Owns the access state, timeout counter, latched request fields, Stall and the sticky error flag.
module mem_handshake_fsm
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_op,
  input  logic              is_store,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              stall,
  output logic              mem_err,
  output logic              start,
  output logic              done,
  output logic              abort
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    start   = 1'b0;
    done    = 1'b0;
    abort   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_op) begin
          state_d = ST_ACCESS;
          cnt_d   = '0;
          we_d    = is_store;
          addr_d  = addr;
          wdata_d = wdata;
          start   = 1'b1;
        end
      end
      ST_ACCESS: begin
        // an ack on the last allowed cycle still completes the access
        if (mem_ack) begin
          state_d = ST_IDLE;
          done    = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          err_d   = 1'b1;
          abort   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  // an abandoned access releases the pipeline so the same op is not retried forever
  assign stall = rst_n & (((state_q == ST_IDLE) & mem_op) |
                          ((state_q == ST_ACCESS) & ~mem_ack & ~abort));

  assign mem_req   = (state_q == ST_ACCESS);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_err   = err_q;

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM stage with branch resolution and the MEM/WB pipeline register
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic [DATA_W-1:0]     BranchTarget_in,
  input  logic                  Zero_in,
  input  logic [DATA_W-1:0]     ALU_Result_in,
  input  logic [DATA_W-1:0]     ReadData2_in,
  input  logic [REG_ADDR_W-1:0] WriteReg_in,
  input  logic                  RegWrite_in,
  input  logic                  WriteRemainder_in,
  input  logic                  Branch_in,
  input  logic                  Bne_in,
  input  logic                  MemRead_in,
  input  logic                  MemWrite_in,
  output logic                  Mem_Req,
  output logic                  Mem_We,
  output logic [DATA_W-1:0]     Mem_Addr,
  output logic [DATA_W-1:0]     Mem_WData,
  input  logic                  Mem_Ack,
  input  logic [DATA_W-1:0]     Mem_RData,
  output logic                  Stall,
  output logic                  PCSrc,
  output logic [DATA_W-1:0]     BranchPC,
  output logic [DATA_W-1:0]     ALU_Result_out,
  output logic [DATA_W-1:0]     MemData_out,
  output logic [REG_ADDR_W-1:0] WriteReg_out,
  output logic                  RegWrite_out,
  output logic                  MemToReg_out,
  output logic                  WriteRemainder_out,
  output logic                  Mem_Err
);

  logic mem_op;
  logic acc_start, acc_done, acc_abort;

  // a branch suppresses any memory op it carries
  assign mem_op = (MemRead_in | MemWrite_in) & ~Branch_in;

  mem_handshake_fsm #(
    .DATA_W      (DATA_W),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_fsm (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .mem_op    (mem_op),
    .is_store  (MemWrite_in),
    .addr      (ALU_Result_in),
    .wdata     (ReadData2_in),
    .mem_ack   (Mem_Ack),
    .mem_req   (Mem_Req),
    .mem_we    (Mem_We),
    .mem_addr  (Mem_Addr),
    .mem_wdata (Mem_WData),
    .stall     (Stall),
    .mem_err   (Mem_Err),
    .start     (acc_start),
    .done      (acc_done),
    .abort     (acc_abort)
  );

  logic [REG_ADDR_W-1:0] pend_wreg_q, pend_wreg_d;
  logic                  pend_regwrite_q, pend_regwrite_d;

  logic [DATA_W-1:0]     alu_q, alu_d;
  logic [DATA_W-1:0]     memdata_q, memdata_d;
  logic [REG_ADDR_W-1:0] wreg_q, wreg_d;
  logic                  regwrite_q, regwrite_d;
  logic                  memtoreg_q, memtoreg_d;
  logic                  wrem_q, wrem_d;
  logic                  pcsrc_q, pcsrc_d;
  logic [DATA_W-1:0]     bpc_q, bpc_d;

  always_comb begin
    pend_wreg_d     = pend_wreg_q;
    pend_regwrite_d = pend_regwrite_q;
    if (acc_start) begin
      pend_wreg_d     = WriteReg_in;
      pend_regwrite_d = RegWrite_in;
    end
  end

  // default is a bubble: controls cleared, data fields held
  always_comb begin
    alu_d      = alu_q;
    memdata_d  = memdata_q;
    wreg_d     = wreg_q;
    bpc_d      = bpc_q;
    regwrite_d = 1'b0;
    memtoreg_d = 1'b0;
    wrem_d     = 1'b0;
    pcsrc_d    = 1'b0;
    if (acc_done) begin
      alu_d  = Mem_Addr;
      wreg_d = pend_wreg_q;
      if (!Mem_We) begin
        memdata_d  = Mem_RData;
        memtoreg_d = 1'b1;
        regwrite_d = pend_regwrite_q;
      end
    end else if (!Stall && !Mem_Req && !acc_abort) begin
      alu_d      = ALU_Result_in;
      wreg_d     = WriteReg_in;
      regwrite_d = RegWrite_in & ~Branch_in;
      wrem_d     = WriteRemainder_in & ~Branch_in;
      if (branch_taken(Branch_in, Zero_in, Bne_in)) begin
        pcsrc_d = 1'b1;
        bpc_d   = BranchTarget_in;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pend_wreg_q     <= '0;
      pend_regwrite_q <= 1'b0;
      alu_q           <= '0;
      memdata_q       <= '0;
      wreg_q          <= '0;
      regwrite_q      <= 1'b0;
      memtoreg_q      <= 1'b0;
      wrem_q          <= 1'b0;
      pcsrc_q         <= 1'b0;
      bpc_q           <= '0;
    end else begin
      pend_wreg_q     <= pend_wreg_d;
      pend_regwrite_q <= pend_regwrite_d;
      alu_q           <= alu_d;
      memdata_q       <= memdata_d;
      wreg_q          <= wreg_d;
      regwrite_q      <= regwrite_d;
      memtoreg_q      <= memtoreg_d;
      wrem_q          <= wrem_d;
      pcsrc_q         <= pcsrc_d;
      bpc_q           <= bpc_d;
    end
  end

  assign ALU_Result_out     = alu_q;
  assign MemData_out        = memdata_q;
  assign WriteReg_out       = wreg_q;
  assign RegWrite_out       = regwrite_q;
  assign MemToReg_out       = memtoreg_q;
  assign WriteRemainder_out = wrem_q;
  assign PCSrc              = pcsrc_q;
  assign BranchPC           = bpc_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - scoreboard bench for mem_wb_stage with directed vectors
`timescale 1ns/1ps
module tb_mem_wb_stage;
  import mem_wb_stage_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [31:0] BranchTarget_in, ALU_Result_in, ReadData2_in, Mem_RData;
  logic [4:0]  WriteReg_in;
  logic        Zero_in, RegWrite_in, WriteRemainder_in, Branch_in, Bne_in, MemRead_in, MemWrite_in, Mem_Ack;
  logic        Mem_Req, Mem_We, Stall, PCSrc, RegWrite_out, MemToReg_out, WriteRemainder_out, Mem_Err;
  logic [31:0] Mem_Addr, Mem_WData, BranchPC, ALU_Result_out, MemData_out;
  logic [4:0]  WriteReg_out;

  mem_wb_stage dut (
    .Clk(Clk), .Reset_n(Reset_n), .BranchTarget_in(BranchTarget_in), .Zero_in(Zero_in),
    .ALU_Result_in(ALU_Result_in), .ReadData2_in(ReadData2_in), .WriteReg_in(WriteReg_in),
    .RegWrite_in(RegWrite_in), .WriteRemainder_in(WriteRemainder_in), .Branch_in(Branch_in),
    .Bne_in(Bne_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .Mem_Req(Mem_Req), .Mem_We(Mem_We), .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData),
    .Mem_Ack(Mem_Ack), .Mem_RData(Mem_RData), .Stall(Stall), .PCSrc(PCSrc), .BranchPC(BranchPC),
    .ALU_Result_out(ALU_Result_out), .MemData_out(MemData_out), .WriteReg_out(WriteReg_out),
    .RegWrite_out(RegWrite_out), .MemToReg_out(MemToReg_out),
    .WriteRemainder_out(WriteRemainder_out), .Mem_Err(Mem_Err)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [31:0] target, alu, rd2, rdata;
    logic [4:0]  wreg;
    logic        zero, regw, wrem, br, bne, mrd, mwr;
    int          ack_after;
    logic        e_regw, e_mtr, e_wrem, e_pc;
    logic [31:0] e_alu, e_md, e_bpc;
    logic [4:0]  e_wreg;
    logic        c_data, c_md, c_bpc;
  } vec_t;

  vec_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t nop(input string name);
    vec_t v;
    v = '{name: name, op: OP_RTYPE, target: 32'h0, alu: 32'h0, rd2: 32'h0, rdata: 32'h0,
          wreg: 5'd0, zero: 1'b0, regw: 1'b0, wrem: 1'b0, br: 1'b0, bne: 1'b0, mrd: 1'b0,
          mwr: 1'b0, ack_after: -1, e_regw: 1'b0, e_mtr: 1'b0, e_wrem: 1'b0, e_pc: 1'b0,
          e_alu: 32'h0, e_md: 32'h0, e_bpc: 32'h0, e_wreg: 5'd0,
          c_data: 1'b1, c_md: 1'b0, c_bpc: 1'b0};
    return v;
  endfunction

  // Drives one EX/MEM entry, plays the memory side, returns once the stage has accepted it.
  task automatic issue(input vec_t v, output int stalls, output int reqs, output int bad);
    int acc;
    bit done;
    stalls = 0; reqs = 0; bad = 0; acc = 0; done = 1'b0;
    BranchTarget_in = v.target; ALU_Result_in = v.alu; ReadData2_in = v.rd2;
    WriteReg_in = v.wreg; Zero_in = v.zero; RegWrite_in = v.regw; WriteRemainder_in = v.wrem;
    Branch_in = v.br; Bne_in = v.bne; MemRead_in = v.mrd; MemWrite_in = v.mwr;
    exp_q.push_back(v);
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge Clk);
      if (Mem_Req === 1'b1) begin
        if (acc == v.ack_after) begin
          Mem_Ack = 1'b1;
          Mem_RData = v.rdata;
        end
        acc++;
      end
      #1;
      if (Mem_Req === 1'b1) begin
        reqs++;
        if (Mem_Addr !== v.alu || Mem_We !== v.mwr || (v.mwr && Mem_WData !== v.rd2)) bad++;
      end
      if (Stall === 1'b0) done = 1'b1;
      else stalls++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s.accept: Stall still 1 after 40 cycles, required 0", v.name);
    end
    @(posedge Clk);
    #1;
    Mem_Ack = 1'b0;
  endtask

  task automatic check_all_zero(input string p);
    chk({p, ".Mem_Req"}, Mem_Req, 0);
    chk({p, ".Stall"}, Stall, 0);
    chk({p, ".Mem_We"}, Mem_We, 0);
    chk({p, ".Mem_Addr"}, Mem_Addr, 0);
    chk({p, ".Mem_WData"}, Mem_WData, 0);
    chk({p, ".PCSrc"}, PCSrc, 0);
    chk({p, ".BranchPC"}, BranchPC, 0);
    chk({p, ".ALU_Result_out"}, ALU_Result_out, 0);
    chk({p, ".MemData_out"}, MemData_out, 0);
    chk({p, ".WriteReg_out"}, WriteReg_out, 0);
    chk({p, ".RegWrite_out"}, RegWrite_out, 0);
    chk({p, ".MemToReg_out"}, MemToReg_out, 0);
    chk({p, ".WriteRemainder_out"}, WriteRemainder_out, 0);
    chk({p, ".Mem_Err"}, Mem_Err, 0);
  endtask

  // Monitor: after every cycle in which the stage accepted an entry, compare MEM/WB to the oldest expectation.
  initial begin
    bit   pend;
    vec_t e;
    pend = 1'b0;
    forever begin
      @(negedge Clk);
      if (pend) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL scoreboard_underflow: got an accepted entry, required a queued expectation");
        end else begin
          e = exp_q.pop_front();
          chk({e.name, ".RegWrite_out"}, RegWrite_out, e.e_regw);
          chk({e.name, ".MemToReg_out"}, MemToReg_out, e.e_mtr);
          chk({e.name, ".WriteRemainder_out"}, WriteRemainder_out, e.e_wrem);
          chk({e.name, ".PCSrc"}, PCSrc, e.e_pc);
          if (e.c_data) begin
            chk({e.name, ".ALU_Result_out"}, ALU_Result_out, e.e_alu);
            chk({e.name, ".WriteReg_out"}, WriteReg_out, e.e_wreg);
          end
          if (e.c_md) chk({e.name, ".MemData_out"}, MemData_out, e.e_md);
          if (e.c_bpc) chk({e.name, ".BranchPC"}, BranchPC, e.e_bpc);
        end
      end
      #2;
      pend = mon_en && (Reset_n === 1'b1) && (Stall === 1'b0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200us, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int st, rq, bd;
    Reset_n = 1'b0;
    v = nop("init");
    BranchTarget_in = 0; ALU_Result_in = 0; ReadData2_in = 0; WriteReg_in = 0; Zero_in = 0;
    RegWrite_in = 0; WriteRemainder_in = 0; Branch_in = 0; Bne_in = 0; MemRead_in = 0;
    MemWrite_in = 0; Mem_Ack = 0; Mem_RData = 0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    #1;
    check_all_zero("reset");
    @(posedge Clk);
    #1;
    mon_en = 1'b1;

    v = nop("addi"); v.op = OP_ADDI; v.alu = 32'h7; v.wreg = 5'd5; v.regw = 1'b1;
    v.e_regw = 1'b1; v.e_alu = 32'h7; v.e_wreg = 5'd5; v.c_md = 1'b1; v.c_bpc = 1'b1;
    issue(v, st, rq, bd);
    chk("addi.stall_cycles", st, 0);

    v = nop("nop1");
    issue(v, st, rq, bd);

    v = nop("div"); v.alu = 32'h3; v.wreg = 5'd9; v.regw = 1'b1; v.wrem = 1'b1;
    v.e_regw = 1'b1; v.e_wrem = 1'b1; v.e_alu = 32'h3; v.e_wreg = 5'd9;
    issue(v, st, rq, bd);

    v = nop("load"); v.alu = 32'h40; v.wreg = 5'd8; v.regw = 1'b1; v.mrd = 1'b1;
    v.ack_after = 3; v.rdata = 32'hDEAD_BEEF;
    v.e_regw = 1'b1; v.e_mtr = 1'b1; v.e_alu = 32'h40; v.e_wreg = 5'd8;
    v.e_md = 32'hDEAD_BEEF; v.c_md = 1'b1;
    issue(v, st, rq, bd);
    chk("load.stall_cycles", st, 4);
    chk("load.req_cycles", rq, 4);
    chk("load.req_fields_unstable", bd, 0);

    v = nop("beq_z1"); v.op = OP_BEQ; v.br = 1'b1; v.zero = 1'b1; v.target = 32'h100;
    v.e_pc = 1'b1; v.e_bpc = 32'h100; v.c_bpc = 1'b1;
    issue(v, st, rq, bd);

    v = nop("after_beq");
    issue(v, st, rq, bd);

    v = nop("bne_z1"); v.op = OP_BNE; v.br = 1'b1; v.bne = 1'b1; v.zero = 1'b1; v.target = 32'h200;
    issue(v, st, rq, bd);

    v = nop("bne_z0"); v.op = OP_BNE; v.br = 1'b1; v.bne = 1'b1; v.target = 32'h300; v.alu = 32'h5;
    v.e_pc = 1'b1; v.e_bpc = 32'h300; v.c_bpc = 1'b1; v.e_alu = 32'h5;
    issue(v, st, rq, bd);

    v = nop("beq_with_load"); v.op = OP_BEQ; v.br = 1'b1; v.mrd = 1'b1; v.regw = 1'b1;
    v.target = 32'h400; v.alu = 32'h80; v.e_alu = 32'h80;
    issue(v, st, rq, bd);
    chk("beq_with_load.stall_cycles", st, 0);
    chk("beq_with_load.req_cycles", rq, 0);

    v = nop("store_ack15"); v.mrd = 1'b1; v.mwr = 1'b1; v.alu = 32'h44; v.rd2 = 32'hCAFE_F00D;
    v.wreg = 5'd3; v.regw = 1'b1; v.ack_after = 14;
    v.e_alu = 32'h44; v.e_wreg = 5'd3;
    issue(v, st, rq, bd);
    chk("store_ack15.stall_cycles", st, 15);
    chk("store_ack15.req_cycles", rq, 15);
    chk("store_ack15.req_fields_unstable", bd, 0);
    chk("store_ack15.Mem_Err", Mem_Err, 0);

    v = nop("store_timeout"); v.mwr = 1'b1; v.alu = 32'h48; v.rd2 = 32'h1111_2222; v.wreg = 5'd4;
    v.regw = 1'b1; v.c_data = 1'b0;
    issue(v, st, rq, bd);
    chk("store_timeout.req_cycles", rq, 15);
    chk("store_timeout.req_fields_unstable", bd, 0);
    chk("store_timeout.Mem_Req_after", Mem_Req, 0);
    chk("store_timeout.Mem_Err", Mem_Err, 1);

    v = nop("nop_after_timeout");
    issue(v, st, rq, bd);
    chk("nop_after_timeout.Mem_Err_sticky", Mem_Err, 1);

    mon_en = 1'b0;
    ALU_Result_in = 32'h50; WriteReg_in = 5'd6; RegWrite_in = 1'b1; MemRead_in = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    #1;
    chk("async_reset.Mem_Req_before", Mem_Req, 1);
    #1;
    Reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    ALU_Result_in = 0; WriteReg_in = 0; RegWrite_in = 0; MemRead_in = 0;
    @(posedge Clk);
    @(negedge Clk);
    #1;
    Reset_n = 1'b1;
    @(negedge Clk);
    Mem_Ack = 1'b1;
    Mem_RData = 32'h1234_5678;
    @(posedge Clk);
    #1;
    Mem_Ack = 1'b0;
    chk("late_ack.Mem_Req", Mem_Req, 0);
    chk("late_ack.Stall", Stall, 0);
    chk("late_ack.MemToReg_out", MemToReg_out, 0);
    chk("late_ack.MemData_out", MemData_out, 0);
    mon_en = 1'b1;

    v = nop("nop_after_reset"); v.c_md = 1'b1; v.c_bpc = 1'b1;
    issue(v, st, rq, bd);
    mon_en = 1'b0;
    @(negedge Clk);
    #3;
    chk("scoreboard.drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
